// File: rtl/vga_timing_gen_if.sv
// Raster coordinate and sync bus from the VGA timing generator to its consumers
// (tile/bounds map, sprite drawing).
interface vga_timing_gen_if;
   logic [9:0] hcount;
   logic [9:0] vcount;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       pixel_tick;
   logic       line_start;
   logic       frame_start;

   modport master (
      output hcount, vcount, hsync, vsync, video_on, pixel_tick, line_start, frame_start
   );

   modport slave (
      input hcount, vcount, hsync, vsync, video_on, pixel_tick, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: prescaled pixel clock enable, h/v counters, sync,
// active-video flag and line/frame strobes, all registered.
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned CLK_DIV   = 2,
   parameter bit          SYNC_POL  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   vga_timing_gen_if.master vga
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
   localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]    H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0]    V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0]    HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0]    HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0]    VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0]    VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end
   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end

   logic [PW-1:0] prescale_q, prescale_d;
   logic [9:0]    hcount_q, hcount_d;
   logic [9:0]    vcount_q, vcount_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          video_on_q, video_on_d;
   logic          pixel_tick_q, pixel_tick_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic          advance;

   always_comb begin
      advance    = (prescale_q == PRE_LAST);
      prescale_d = prescale_q + PW'(1);
      hcount_d   = hcount_q;
      vcount_d   = vcount_q;

      if (advance) begin
         prescale_d = '0;
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
         end else begin
            hcount_d = hcount_q + 10'd1;
         end
      end

      // Decoded from next counter values so everything moves on the same edge
      hsync_d       = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      video_on_d    = (hcount_d < H_VIS) && (vcount_d < V_VIS);
      pixel_tick_d  = advance;
      line_start_d  = advance && (hcount_d == 10'd0);
      frame_start_d = line_start_d && (vcount_d == 10'd0);
   end

   // Reset parks the counters on the last coordinate so the first advance is a frame start
   always_ff @(posedge clk) begin
      if (reset) begin
         prescale_q    <= '0;
         hcount_q      <= H_LAST;
         vcount_q      <= V_LAST;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         video_on_q    <= 1'b0;
         pixel_tick_q  <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         prescale_q    <= prescale_d;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         pixel_tick_q  <= pixel_tick_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.hcount      = hcount_q;
   assign vga.vcount      = vcount_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.video_on    = video_on_q;
   assign vga.pixel_tick  = pixel_tick_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA raster timing: pixel-rate hcount/vcount coordinates, hsync/vsync and the active-video flag.
It produces the hcount/vcount bus consumed by the tile/bounds map and sprite drawing logic.
It runs from the system clock and derives the pixel rate with an internal prescaler.
Defaults give 640x480@60 Hz from a 50 MHz clock (25 MHz pixel rate).

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines); V_TOTAL = sum = 525
CLK_DIV, 2, system clocks per pixel (>=1)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
hcount  out  10  current pixel column, 0..H_TOTAL-1
vcount  out  10  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
video_on  out  1  high when hcount<H_VISIBLE and vcount<V_VISIBLE
pixel_tick  out  1  one-clk strobe: new pixel coordinate valid this cycle
line_start  out  1  one-clk strobe coincident with pixel_tick when hcount becomes 0
frame_start  out  1  one-clk strobe coincident with pixel_tick when (hcount,vcount) becomes (0,0)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All outputs are registered.
- Reset values, applied at any clk edge with reset=1, including mid-frame:
  - prescaler=0, hcount=H_TOTAL-1 (799), vcount=V_TOTAL-1 (524)
  - hsync=vsync=~SYNC_POL (inactive)
  - video_on=0, pixel_tick=0, line_start=0, frame_start=0
  - These values are consistent with the counter position, so the first tick is a clean frame start.
- Prescaler:
  - Counts 0..CLK_DIV-1 on each edge with reset=0.
  - An "advance" edge is one where prescaler==CLK_DIV-1; the prescaler returns to 0 on that edge.
  - When CLK_DIV=1, every edge is an advance edge.
- On an advance edge:
  - hcount increments; if hcount==H_TOTAL-1 it wraps to 0 and vcount increments.
  - If vcount==V_TOTAL-1 at that same wrap, vcount wraps to 0.
- Sync, video and strobe outputs are computed from the next counter values, so they change on the same edge as the counters:
  - hsync active iff H_VISIBLE+H_FRONT <= hcount <= H_VISIBLE+H_FRONT+H_SYNC-1 (656..751).
  - vsync active iff V_VISIBLE+V_FRONT <= vcount <= V_VISIBLE+V_FRONT+V_SYNC-1 (490..491).
  - video_on as defined under Ports.
  - pixel_tick=1 for exactly the cycle after each advance edge, else 0.
  - line_start=1 when pixel_tick=1 and hcount=0.
  - frame_start=1 when pixel_tick=1 and hcount=0 and vcount=0.
- Latency from reset release: the first advance occurs on the CLK_DIV-th edge with reset=0, producing (0,0), video_on=1, pixel_tick=line_start=frame_start=1.
- Timing per coordinate:
  - Each coordinate is held for exactly CLK_DIV clocks.
  - Line period = H_TOTAL*CLK_DIV clocks.
  - Frame period = H_TOTAL*V_TOTAL*CLK_DIV clocks (840000 by default).
  - With CLK_DIV=1, pixel_tick stays 1 continuously after the first advance.
- Widths: hcount/vcount are 10 bits. H_TOTAL and V_TOTAL must be <=1024; an elaboration-time check flags violations.
- Counters never exceed TOTAL-1; there are no illegal states.
- Reset asserted on an advance edge: reset wins; no advance and no strobes are produced.

Test Plan:
1. Reset held for 3 clks, then released (default params) -> during reset hcount=799, vcount=524, hsync=vsync=1, video_on=0. On the 2nd post-reset edge: hcount=0, vcount=0, video_on=1, pixel_tick=line_start=frame_start=1 for one clk.
2. Run one line -> hsync falls when hcount=656 and rises when hcount=752. video_on falls at hcount=640. At hcount 799->0: vcount 0->1, line_start=1, frame_start=0. Consecutive line_starts are 1600 clks apart.
3. Run a full frame -> vsync=0 exactly for vcount 490 and 491. video_on=0 for all vcount>=480. frame_start pulses are 840000 clks apart; vcount wraps 524->0.
4. Reset asserted mid-frame at (hcount=300, vcount=200) on an advance edge -> the next edge shows (799,524) with all strobes 0. The restart sequence matches scenario 1.
5. CLK_DIV=1, SYNC_POL=1 -> pixel_tick constant 1 after the first advance. hcount increments every clk. hsync=1 for hcount 656..751 and 0 otherwise. Frame period is 420000 clks.
6. Coordinate sampling: compare hcount/vcount against the map's expected points, e.g. (150,450) -> hcount=150 and vcount=450 appear for exactly CLK_DIV clks with video_on=1.
